alu_issue_ctrl: RTL and testbench

- Sequencer on the driving end of the ALU interface: accepts one RV32I register-register or register-immediate instruction per handshake.
- Decodes the instruction into a 4-bit ALU operation code.
- Reads source registers, drives ALU operands and operation, captures the ALU result and writes it back to the register file.
- Sits between the fetch stage and the register file/ALU pair in the multi-cycle core.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_issue_decode.sv | 72 +++++++
 rtl/alu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue sequencer: op codes, opcodes, FSM states.
// base_op() maps funct3 to the op code used when funct7 carries no modifier.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_ERR  = 4'd10;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I OP/OP-IMM decoder: instruction word -> ALU op code,
// immediate select/value and an illegal flag.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       instr,
  output logic [3:0]        alu_op,
  output logic              use_imm,
  output logic [DATA_W-1:0] imm,
  output logic              illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_shift;
  logic       unused_fields;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign unused_fields = ^instr[19:7];

  always_comb begin
    alu_op  = ALU_ERR;
    use_imm = 1'b0;
    imm     = '0;
    illegal = 1'b1;
    case (opc)
      OP_REG: begin
        if (f7 == F7_ZERO) begin
          alu_op  = base_op(f3);
          illegal = 1'b0;
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          alu_op  = ALU_SUB;
          illegal = 1'b0;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          alu_op  = ALU_SRA;
          illegal = 1'b0;
        end
      end
      OP_IMM: begin
        use_imm = 1'b1;
        if (!is_shift) begin
          alu_op  = base_op(f3);
          imm     = {{(DATA_W-12){instr[31]}}, instr[31:20]};
          illegal = 1'b0;
        end else begin
          imm = {{(DATA_W-5){1'b0}}, instr[24:20]};
          if (f7 == F7_ZERO) begin
            alu_op  = base_op(f3);
            illegal = 1'b0;
          end else if (f7 == F7_ALT && f3 == 3'b101) begin
            alu_op  = ALU_SRA;
            illegal = 1'b0;
          end
        end
      end
      default: ;
    endcase
    // Illegal encodings issue ERR with zero operands regardless of opcode.
    if (illegal) begin
      alu_op  = ALU_ERR;
      use_imm = 1'b0;
      imm     = '0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue sequencer: accept, read/decode, execute, write back.
// One instruction in flight; the latched copy drives everything after accept.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter bit RD0_SUPPRESS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rd_we,
  output logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              illegal,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   in1_q, in1_d, in2_q, in2_d, rdd_q, rdd_d;
  logic [3:0]          op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                ill_q, ill_d;

  logic [3:0]          dec_op;
  logic                dec_use_imm, dec_ill;
  logic [DATA_W-1:0]   dec_imm;

  alu_issue_decode #(.DATA_W(DATA_W)) u_dec (
    .instr   (instr_q),
    .alu_op  (dec_op),
    .use_imm (dec_use_imm),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rdd_d   = rdd_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        in1_d   = dec_ill ? '0 : rs1_data;
        in2_d   = dec_ill ? '0 : (dec_use_imm ? dec_imm : rs2_data);
        op_d    = dec_op;
        rd_d    = instr_q[11:7];
        ill_d   = dec_ill;
        state_d = EXEC;
      end
      EXEC: begin
        rdd_d   = alu_out;
        state_d = WB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rdd_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rdd_q   <= rdd_d;
      ill_q   <= ill_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rs1_addr    = instr_q[19:15];
  assign rs2_addr    = instr_q[24:20];
  assign alu_in_1    = in1_q;
  assign alu_in_2    = in2_q;
  assign alu_op      = op_q;
  assign rd_addr     = rd_q;
  assign rd_data     = rdd_q;
  // Strobes are decoded from the WB state so they last exactly one cycle.
  assign rd_we   = (state_q == WB) && !ill_q && !(RD0_SUPPRESS && rd_q == '0);
  assign illegal = (state_q == WB) && ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: hand-computed vectors walked through
// every FSM stage, back-to-back throughput and asynchronous reset.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, alu_in_1, alu_in_2, alu_out, rd_data;
  logic [3:0]  alu_op;
  logic        rd_we, illegal, busy;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5), .RD0_SUPPRESS(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .alu_in_1    (alu_in_1),
    .alu_in_2    (alu_in_2),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .rd_we       (rd_we),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .illegal     (illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one instruction at the next posedge and check each stage at negedge.
  // chk_ex=0 skips the EXEC operand/op checks (only strobes matter there).
  task automatic run(input string nm, input logic [31:0] ins,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] ao,
                     input bit chk_ex, input logic [3:0] e_op,
                     input logic [31:0] e_a1, input logic [31:0] e_a2,
                     input logic e_we, input logic [4:0] e_rd, input logic e_ill);
    @(negedge clk);
    instr = ins; rs1_data = r1; rs2_data = r2; alu_out = ao; instr_valid = 1'b1;
    chk({nm, ".ready"}, {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 32'hDEAD_BEEF;
    chk({nm, ".dec_busy"}, {31'd0, busy}, 32'd1);
    chk({nm, ".dec_rs1"}, {27'd0, rs1_addr}, {27'd0, ins[19:15]});
    chk({nm, ".dec_rs2"}, {27'd0, rs2_addr}, {27'd0, ins[24:20]});
    @(negedge clk);
    if (chk_ex) begin
      chk({nm, ".ex_op"}, {28'd0, alu_op}, {28'd0, e_op});
      chk({nm, ".ex_in1"}, alu_in_1, e_a1);
      chk({nm, ".ex_in2"}, alu_in_2, e_a2);
    end
    chk({nm, ".ex_we"}, {31'd0, rd_we}, 32'd0);
    @(negedge clk);
    chk({nm, ".wb_we"}, {31'd0, rd_we}, {31'd0, e_we});
    chk({nm, ".wb_ill"}, {31'd0, illegal}, {31'd0, e_ill});
    chk({nm, ".wb_rd"}, {27'd0, rd_addr}, {27'd0, e_rd});
    if (e_we) chk({nm, ".wb_data"}, rd_data, ao);
    @(negedge clk);
    chk({nm, ".idle_ready"}, {31'd0, instr_ready}, 32'd1);
    chk({nm, ".idle_we"}, {31'd0, rd_we}, 32'd0);
    chk({nm, ".idle_ill"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    int acc [$];
    bit seen_we;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    rs1_data = '0; rs2_data = '0; alu_out = '0;
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'd0, instr_ready}, 32'd1);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.op", {28'd0, alu_op}, 32'd0);
    chk("rst.in1", alu_in_1, 32'd0);
    chk("rst.rs1", {27'd0, rs1_addr}, 32'd0);
    chk("rst.rdata", rd_data, 32'd0);
    chk("rst.we", {31'd0, rd_we}, 32'd0);
    rst = 1'b0;

    //      name     instr         rs1         rs2         alu_out      ex op  in1          in2          we rd ill
    run("addi",   32'hFFF00293, 32'd0,        32'd0,      32'hFFFFFFFF, 1, 4'd0, 32'd0,        32'hFFFFFFFF, 1, 5'd5, 0);
    run("sub",    32'h402081B3, 32'd10,       32'd3,      32'd7,        1, 4'd1, 32'd10,       32'd3,        1, 5'd3, 0);
    run("srai",   32'h40435393, 32'h80000000, 32'd9,      32'hF8000000, 1, 4'd7, 32'h80000000, 32'd4,        1, 5'd7, 0);
    run("srai_bad", 32'h60435393, 32'd1,      32'd2,      32'd3,        0, 4'd0, 32'd0,        32'd0,        0, 5'd7, 1);
    run("ecall",  32'h00000073, 32'h55,       32'h66,     32'h77,       1, 4'd10, 32'd0,       32'd0,        0, 5'd0, 1);
    run("addi_x0", 32'h00508013, 32'd20,      32'd0,      32'd25,       1, 4'd0, 32'd20,       32'd5,        0, 5'd0, 0);
    run("xor",    32'h0020C233, 32'h0F0F,     32'h00FF,   32'h0FF0,     1, 4'd2, 32'h0F0F,     32'h00FF,     1, 5'd4, 0);
    run("sltu",   32'h0020B233, 32'd1,        32'd2,      32'd1,        1, 4'd9, 32'd1,        32'd2,        1, 5'd4, 0);
    run("or_f7bad", 32'h0220E233, 32'd1,      32'd2,      32'd3,        0, 4'd0, 32'd0,        32'd0,        0, 5'd4, 1);

    // Back-to-back: valid held high, accepts must be 4 cycles apart.
    @(negedge clk);
    instr = 32'h00508013; rs1_data = 32'd1; alu_out = 32'd6; instr_valid = 1'b1;
    seen_we = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (instr_ready) acc.push_back(c);
      if (rd_we) seen_we = 1'b1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("b2b.count", acc.size(), 32'd3);
    if (acc.size() >= 2) chk("b2b.gap", acc[1] - acc[0], 32'd4);
    chk("b2b.no_we_x0", {31'd0, seen_we}, 32'd0);
    repeat (4) @(negedge clk);

    // Reset during EXEC discards the in-flight instruction.
    @(negedge clk);
    instr = 32'h402081B3; rs1_data = 32'd10; rs2_data = 32'd3; alu_out = 32'd7; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid.exec_op", {28'd0, alu_op}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid.ready", {31'd0, instr_ready}, 32'd1);
    chk("mid.busy", {31'd0, busy}, 32'd0);
    chk("mid.op", {28'd0, alu_op}, 32'd0);
    chk("mid.in1", alu_in_1, 32'd0);
    chk("mid.in2", alu_in_2, 32'd0);
    chk("mid.rd", {27'd0, rd_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_we = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rd_we || illegal) seen_we = 1'b1;
      @(negedge clk);
    end
    chk("mid.no_wb", {31'd0, seen_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
